// File: rtl/mult_hilo_ctrl.sv
// HI/LO multiply control: operand magnitudes out, sign-corrected product in.
// Define MULT_HILO_BYPASS_EN to forward the product to MFHI/MFLO on capture.
module mult_hilo_ctrl #(
  parameter int WIDTH_D  = 32,
  parameter int MULT_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  input  logic [2:0]             op_code,
  input  logic [WIDTH_D-1:0]     op_a,
  input  logic [WIDTH_D-1:0]     op_b,
  input  logic                   flush,
  output logic                   stall_out,
  output logic                   rd_valid,
  output logic [WIDTH_D-1:0]     rd_data,
  output logic [WIDTH_D-1:0]     mul_a,
  output logic [WIDTH_D-1:0]     mul_b,
  input  logic [2*WIDTH_D-1:0]   mul_p,
  output logic [WIDTH_D-1:0]     hi,
  output logic [WIDTH_D-1:0]     lo
);

  localparam int CL = $clog2(MULT_LAT + 1);
  localparam int CW = (CL < 1) ? 1 : CL;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MFHI  = 3'b011;
  localparam logic [2:0] OP_MFLO  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [WIDTH_D-1:0]   D_ONE = {{(WIDTH_D-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH_D-1:0] P_ONE = {{(2*WIDTH_D-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        C_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        C_LAT = CW'(MULT_LAT);

  logic                 state;
  logic [CW-1:0]        cnt;
  logic                 neg;

  logic                 is_mul;
  logic                 is_mf;
  logic                 is_mt;
  logic                 cap;
  logic                 byp;
  logic                 take;
  logic                 neg_nxt;
  logic [WIDTH_D-1:0]   mag_a;
  logic [WIDTH_D-1:0]   mag_b;
  logic [WIDTH_D-1:0]   src_hi;
  logic [WIDTH_D-1:0]   src_lo;
  logic [2*WIDTH_D-1:0] prod;

  always_comb begin
    is_mul = 1'b0;
    is_mf  = 1'b0;
    is_mt  = 1'b0;
    unique case (op_code)
      OP_MULT, OP_MULTU: is_mul = 1'b1;
      OP_MFHI, OP_MFLO:  is_mf  = 1'b1;
      OP_MTHI, OP_MTLO:  is_mt  = 1'b1;
      default: ;
    endcase
  end

  // Signed MULT hands the multiplier magnitudes; the sign is restored on capture.
  always_comb begin
    mag_a   = op_a;
    mag_b   = op_b;
    neg_nxt = 1'b0;
    if (op_code == OP_MULT) begin
      if (op_a[WIDTH_D-1]) mag_a = ~op_a + D_ONE;
      if (op_b[WIDTH_D-1]) mag_b = ~op_b + D_ONE;
      neg_nxt = op_a[WIDTH_D-1] ^ op_b[WIDTH_D-1];
    end
  end

  assign prod = neg ? (~mul_p + P_ONE) : mul_p;
  assign cap  = (state == BUSY) && (cnt == '0);

`ifdef MULT_HILO_BYPASS_EN
  assign byp = cap & is_mf;
`else
  assign byp = 1'b0;
`endif

  assign stall_out = op_valid & ~flush & (state == BUSY)
                   & (is_mul | is_mf | is_mt) & ~byp;
  assign take      = op_valid & ~flush & ~stall_out;
  assign rd_valid  = take & is_mf;

  assign src_hi  = byp ? prod[2*WIDTH_D-1:WIDTH_D] : hi;
  assign src_lo  = byp ? prod[WIDTH_D-1:0] : lo;
  assign rd_data = !rd_valid ? '0
                 : (op_code == OP_MFHI) ? src_hi : src_lo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == BUSY) begin
      if (cnt != '0) begin
        cnt <= cnt - C_ONE;
      end else begin
        {hi, lo} <= prod;
        state    <= IDLE;
      end
    end else if (take) begin
      if (is_mul) begin
        mul_a <= mag_a;
        mul_b <= mag_b;
        neg   <= neg_nxt;
        cnt   <= C_LAT;
        state <= BUSY;
      end
      if (op_code == OP_MTHI) hi <= op_a;
      if (op_code == OP_MTLO) lo <= op_a;
    end
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Random + directed bench for mult_hilo_ctrl against a cycle-indexed model.
// Honours MULT_HILO_BYPASS_EN the same way the design does.
module tb_mult_hilo_ctrl;
  localparam int W = 32;
  localparam int L = 1;

`ifdef MULT_HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           op_valid = 1'b0;
  logic [2:0]     op_code = 3'd0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic           flush = 1'b0;
  logic           stall_out;
  logic           rd_valid;
  logic [W-1:0]   rd_data;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_p;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;

  logic [2*W-1:0] pipe [L];

  mult_hilo_ctrl #(.WIDTH_D(W), .MULT_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid),
    .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall_out(stall_out),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier with L register stages.
  always @(posedge clk) begin
    pipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[L-1];

  logic [W-1:0]   m_hi = '0, m_lo = '0, m_ma = '0, m_mb = '0;
  logic [2*W-1:0] m_prod = '0;
  bit             m_pend = 1'b0;
  int             m_cap = 0;
  int             cyc = 0;
  int             n_chk = 0;
  int             n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] absv(input logic [W-1:0] x);
    return x[W-1] ? (W'(0) - x) : x;
  endfunction

  task automatic step(input logic v, input logic [2:0] c,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic f);
    logic listed, mf, cp, stl, rdv;
    logic [W-1:0] sh, sl, rdd;
    longint sp;
    op_valid = v; op_code = c; op_a = a; op_b = b; flush = f;
    #2;
    listed = (c >= 3'd1) && (c <= 3'd6);
    mf  = (c == 3'd3) || (c == 3'd4);
    cp  = m_pend && (cyc == m_cap);
    stl = v && !f && m_pend && listed && !(BYP && cp && mf);
    rdv = v && !f && !stl && mf;
    sh  = (BYP && cp) ? m_prod[2*W-1:W] : m_hi;
    sl  = (BYP && cp) ? m_prod[W-1:0] : m_lo;
    rdd = !rdv ? '0 : (c == 3'd3) ? sh : sl;
    check("stall", 64'(stall_out), 64'(stl));
    check("rd_valid", 64'(rd_valid), 64'(rdv));
    check("rd_data", 64'(rd_data), 64'(rdd));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("mul_a", 64'(mul_a), 64'(m_ma));
    check("mul_b", 64'(mul_b), 64'(m_mb));
    @(posedge clk);
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_ma = '0; m_mb = '0; m_pend = 1'b0;
    end else if (f) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (cyc == m_cap) begin
        {m_hi, m_lo} = m_prod;
        m_pend = 1'b0;
      end
    end else if (v) begin
      case (c)
        3'd1: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          m_prod = sp;
          m_ma = absv(a); m_mb = absv(b);
          m_pend = 1'b1; m_cap = cyc + 1 + L;
        end
        3'd2: begin
          m_prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
          m_ma = a; m_mb = b;
          m_pend = 1'b1; m_cap = cyc + 1 + L;
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0, '0, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return '0;
      3: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(1'b0, 3'd0, '0, '0, 1'b0);
    rst_n = 1'b1;

    step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h2, 1'b0);
    step(1'b1, 3'd3, '0, '0, 1'b0);
    step(1'b1, 3'd3, '0, '0, 1'b0);
    check("tp1_hi", 64'(hi), 64'h1);
    check("tp1_lo", 64'(lo), 64'hFFFF_FFFE);

    step(1'b1, 3'd1, 32'hFFFF_FFFD, 32'h7, 1'b0);
    check("tp2_mul_a", 64'(mul_a), 64'h3);
    check("tp2_mul_b", 64'(mul_b), 64'h7);
    idle(L + 1);
    check("tp2_hi", 64'(hi), 64'hFFFF_FFFF);
    check("tp2_lo", 64'(lo), 64'hFFFF_FFEB);

    step(1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    idle(L + 1);
    check("tp3_hi", 64'(hi), 64'h4000_0000);
    check("tp3_lo", 64'(lo), 64'h0);
    op_valid = 1'b1; op_code = 3'd3; #2;
    check("tp3_rdv", 64'(rd_valid), 64'h1);
    check("tp3_rd", 64'(rd_data), 64'h4000_0000);
    step(1'b1, 3'd3, '0, '0, 1'b0);

    step(1'b1, 3'd6, 32'h1234_5678, '0, 1'b0);
    step(1'b1, 3'd4, '0, '0, 1'b0);
    check("tp4_hi", 64'(hi), 64'h4000_0000);
    step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'h3, 1'b0);
    for (int i = 0; i < L + 2; i++) step(1'b1, 3'd3, '0, '0, 1'b0);

    step(1'b1, 3'd5, 32'hAAAA_0001, '0, 1'b0);
    step(1'b1, 3'd6, 32'hBBBB_0002, '0, 1'b0);
    step(1'b1, 3'd1, 32'd5, 32'd6, 1'b0);
    idle(L);
    step(1'b1, 3'd3, '0, '0, 1'b1);
    check("tp5_hi", 64'(hi), 64'hAAAA_0001);
    check("tp5_lo", 64'(lo), 64'hBBBB_0002);
    check("tp5_stall", 64'(stall_out), 64'h0);
    step(1'b1, 3'd2, 32'd5, 32'd6, 1'b0);
    idle(L + 1);
    check("tp5_lo2", 64'(lo), 64'h1E);
    check("tp5_hi2", 64'(hi), 64'h0);

    step(1'b1, 3'd5, 32'h5555_5555, '0, 1'b0);
    step(1'b1, 3'd1, 32'd7, 32'd9, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 3'd0, '0, '0, 1'b0);
    rst_n = 1'b1;
    idle(L + 3);
    check("tp6_hi", 64'(hi), 64'h0);
    check("tp6_lo", 64'(lo), 64'h0);

    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           pick(), pick(), $urandom_range(0, 15) == 0);
    idle(L + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
